i2s_tdm_dec: RTL and testbench
==============================

# i2s_tdm_dec

I2S/TDM serial decoder, the receive-side counterpart to the I2S TDM encoder. It oversamples `bclk`, `lrclk` and the serial data line with `mclk`, deserialises each slot into a parallel sample and presents it with its channel index on a valid/ready output. It sits between the external codec/ADC pins and the channel mixer/processing chain. Loopback against the encoder with identical parameters must be bit-exact.

## Interface
- `NR_CHANNELS`, 4: slots per frame, minimum 2.
- `OUTPUT_WIDTH`, 24: bits per slot and sample width, minimum 8.
- `LRCLK_POLARITY`, 1: `lrclk` level that marks frame start; 0 = I2S, 1 = TDM.
- `LEFT_ALIGNED`, 1: 1 = MSB on the frame-start bit (TDM), 0 = MSB one `bclk` later (I2S).
- `MCLK_BCLK_RATIO`, 4: `mclk`/`bclk` ratio; allowed values are 2 or at least 4.

Ports:
- `mclk`  in  1  master clock; the only clock.
- `rst_n`  in  1  reset; one clock, asynchronous assert, active-low.
- `bclk`  in  1  bit clock, sampled as data.
- `lrclk`  in  1  frame clock, sampled as data.
- `i2s_tdm`  in  1  serial data line.
- `i2s_tdm_d`  out  OUTPUT_WIDTH  decoded sample, two's complement, MSB first on the wire.
- `i2s_tdm_ch`  out  clog2(NR_CHANNELS)  slot index of `i2s_tdm_d`.
- `i2s_tdm_dv`  out  1  sample valid.
- `i2s_tdm_dr`  in  1  sample ready.
- `frame_err`  out  1  one-`mclk` pulse on framing error or overrun.

## Operation
- **Input synchronisation:** `bclk`, `lrclk` and `i2s_tdm` each pass through a two-flop synchroniser and a delay flop. A bit event occurs on a rising `bclk` edge, detected when the synchronised value is 1 and the delayed value is 0. All three inputs see equal delay.
- **Frame start:** on a bit event where synchronised `lrclk` equals `LRCLK_POLARITY` and the previously sampled `lrclk` differs.
- **States:**
  - IDLE: after reset. Ignores data until a frame start, then goes to DELAY if `LEFT_ALIGNED`=0, otherwise to SHIFT with this bit taken as the MSB of slot 0.
  - DELAY: discards exactly one bit, then goes to SHIFT.
  - SHIFT: shifts data in MSB first and counts bits 0..OUTPUT_WIDTH-1. At count OUTPUT_WIDTH-1 it loads the output register with slot = slot counter, then increments the slot counter. Past slot NR_CHANNELS-1 it goes to WAIT.
  - WAIT: ignores the padding bits until the next frame start, then re-enters as from IDLE.
- **Frame start inside SHIFT with slot counter ≠ 0 or bit counter ≠ 0 (short frame):**
  - Pulse `frame_err` and discard the partial slot.
  - Resynchronise: slot counter = 0; apply the DELAY rule.
- **Output register:** single entry.
  - Transfer happens on `i2s_tdm_dv && i2s_tdm_dr`.
  - If a new sample completes while `i2s_tdm_dv`=1 and `i2s_tdm_dr`=0 in the same cycle, keep the old sample, drop the new one and pulse `frame_err`.
  - If the transfer and the new completion occur in the same cycle, load the new sample and keep `dv`=1.
- **Counter widths:**
  - Bit counter is clog2(OUTPUT_WIDTH+1) bits.
  - Slot counter is clog2(NR_CHANNELS) bits. It never wraps to 0 mid-frame; exhausting it forces WAIT.

## Timing
- **Reset values:** `i2s_tdm_d`=0, `i2s_tdm_ch`=0, `i2s_tdm_dv`=0, `frame_err`=0, state IDLE, counters 0.
- **Reset mid-frame:** clears all of the above; the first sample after release comes from the next complete frame.
- **Latency:** pin `bclk` rise to bit event is 3 `mclk` cycles. LSB bit event to `i2s_tdm_dv`=1 is 1 `mclk` cycle.
- **Handshake:** `dv` deasserts the cycle after a transfer unless a new sample loads. `d` and `ch` are stable while `dv`=1 and `dr`=0.
- **Ratio 2:** a bit event occurs on every second `mclk`. The pipeline must sustain this with no stall.

## Structure
- **Package `i2s_tdm_pkg`:**
  - `clog2` function.
  - State encoding: IDLE, DELAY, SHIFT, WAIT.
  - Alignment/polarity constants shared with the encoder.
- **Sub-module `i2s_tdm_sync`:** two-flop synchroniser plus rising/falling edge detect, parameterised by width. The encoder reuses it.

## Test plan
- **TDM loopback:** NR_CHANNELS=4, OUTPUT_WIDTH=24, ratio 4; encoder drives 24'h800001, 24'h7FFFFF, 24'h123456, 24'hABCDEF -> decoder outputs the same values with ch 0..3 in order, repeating every frame.
- **I2S mode:** LRCLK_POLARITY=0, LEFT_ALIGNED=0, 2 channels, 16 bit, ratio 2; stereo 16'hA55A / 16'h5AA5 -> ch0=A55A, ch1=5AA5, no `frame_err`.
- **Backpressure:** `dr` held 0 across two slots -> first sample held, `frame_err` pulses once, the second sample is lost; `dr`=1 -> first sample transfers.
- **Short frame:** frame start injected after 10 bits of slot 2 -> `frame_err` pulse; the next frame decodes ch0 correctly.
- **Padding:** 32 `bclk` per slot position beyond 4×24 bits -> extra bits ignored, exactly 4 samples per frame.
- **Reset mid-slot:** `rst_n` low for 3 `mclk` during slot 1 -> `dv`=0 immediately; next valid output is ch0 of the following complete frame.

Source files
------------

// File: rtl/i2s_tdm_pkg.sv
// Shared definitions for the I2S/TDM encoder and decoder.
package i2s_tdm_pkg;

    localparam logic LRCLK_POL_I2S = 1'b0;
    localparam logic LRCLK_POL_TDM = 1'b1;
    localparam logic ALIGN_I2S     = 1'b0;
    localparam logic ALIGN_LEFT    = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_SHIFT = 2'd2,
        ST_WAIT  = 2'd3
    } dec_state_e;

    // Ceiling log2, used for counter and channel-index widths.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((64'd1 << res) < 64'(value)) begin
            res++;
        end
        return res;
    endfunction

endpackage

// File: rtl/i2s_tdm_sync.sv
// Two-flop synchroniser with a delay stage and rising/falling edge detect.
module i2s_tdm_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] dly,
    output logic [WIDTH-1:0] rise_c,
    output logic [WIDTH-1:0] fall_c
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            sync <= '0;
            dly  <= '0;
        end else begin
            meta <= din;
            sync <= meta;
            dly  <= sync;
        end
    end

    assign rise_c = sync & ~dly;
    assign fall_c = ~sync & dly;

endmodule

// File: rtl/i2s_tdm_dec.sv
// I2S/TDM receive decoder: oversamples the serial pins with mclk and
// presents each slot as a parallel sample with its channel index.
module i2s_tdm_dec
    import i2s_tdm_pkg::*;
#(
    parameter int unsigned NR_CHANNELS     = 4,
    parameter int unsigned OUTPUT_WIDTH    = 24,
    parameter logic        LRCLK_POLARITY  = LRCLK_POL_TDM,
    parameter logic        LEFT_ALIGNED    = ALIGN_LEFT,
    parameter int unsigned MCLK_BCLK_RATIO = 4
) (
    input  logic                          mclk,
    input  logic                          rst_n,
    input  logic                          bclk,
    input  logic                          lrclk,
    input  logic                          i2s_tdm,
    output logic [OUTPUT_WIDTH-1:0]       i2s_tdm_d,
    output logic [clog2(NR_CHANNELS)-1:0] i2s_tdm_ch,
    output logic                          i2s_tdm_dv,
    input  logic                          i2s_tdm_dr,
    output logic                          frame_err
);

    localparam int unsigned CH_W  = clog2(NR_CHANNELS);
    localparam int unsigned CNT_W = clog2(OUTPUT_WIDTH + 1);

    dec_state_e              state, state_nxt;
    logic [CNT_W-1:0]        bit_cnt, bit_nxt;
    logic [CH_W-1:0]         slot_cnt, slot_nxt;
    logic [OUTPUT_WIDTH-1:0] shreg, shreg_nxt;
    logic [OUTPUT_WIDTH-1:0] d_nxt;
    logic [CH_W-1:0]         ch_nxt;
    logic                    dv_nxt, err_nxt;
    logic                    lr_prev, lr_prev_nxt;

    logic [2:0] sync_q, dly_q, rise_c, fall_c;
    logic       bit_evt_c, lr_s_c, sd_s_c, frame_start_c;
    logic       last_bit_c, final_slot_c, restart_c, done_c;
    logic [OUTPUT_WIDTH-1:0] shift_c;
    logic       unused_c;

    // bclk, lrclk and data share one synchroniser so they see equal delay.
    i2s_tdm_sync #(
        .WIDTH(3)
    ) u_sync (
        .mclk  (mclk),
        .rst_n (rst_n),
        .din   ({bclk, lrclk, i2s_tdm}),
        .sync  (sync_q),
        .dly   (dly_q),
        .rise_c(rise_c),
        .fall_c(fall_c)
    );

    assign bit_evt_c     = rise_c[2];
    assign lr_s_c        = sync_q[1];
    assign sd_s_c        = sync_q[0];
    assign frame_start_c = bit_evt_c && (lr_s_c == LRCLK_POLARITY) && (lr_prev != LRCLK_POLARITY);
    assign last_bit_c    = (bit_cnt == CNT_W'(OUTPUT_WIDTH - 1));
    assign final_slot_c  = last_bit_c && (slot_cnt == CH_W'(NR_CHANNELS - 1));
    assign shift_c       = {shreg[OUTPUT_WIDTH-2:0], sd_s_c};
    assign unused_c      = ^{sync_q[2], dly_q, fall_c, rise_c[1:0], 32'(MCLK_BCLK_RATIO)};

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            slot_cnt   <= '0;
            shreg      <= '0;
            lr_prev    <= LRCLK_POLARITY;
            i2s_tdm_d  <= '0;
            i2s_tdm_ch <= '0;
            i2s_tdm_dv <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_nxt;
            slot_cnt   <= slot_nxt;
            shreg      <= shreg_nxt;
            lr_prev    <= lr_prev_nxt;
            i2s_tdm_d  <= d_nxt;
            i2s_tdm_ch <= ch_nxt;
            i2s_tdm_dv <= dv_nxt;
            frame_err  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_nxt     = bit_cnt;
        slot_nxt    = slot_cnt;
        shreg_nxt   = shreg;
        lr_prev_nxt = lr_prev;
        d_nxt       = i2s_tdm_d;
        ch_nxt      = i2s_tdm_ch;
        dv_nxt      = i2s_tdm_dv;
        err_nxt     = 1'b0;
        restart_c   = 1'b0;
        done_c      = 1'b0;

        if (i2s_tdm_dv && i2s_tdm_dr) begin
            dv_nxt = 1'b0;
        end

        if (bit_evt_c) begin
            lr_prev_nxt = lr_s_c;
            unique case (state)
                ST_IDLE, ST_WAIT: begin
                    restart_c = frame_start_c;
                end
                ST_DELAY: begin
                    shreg_nxt = shift_c;
                    bit_nxt   = CNT_W'(1);
                    state_nxt = ST_SHIFT;
                end
                ST_SHIFT: begin
                    // In I2S the frame-start bit is also the LSB of the last slot.
                    if (frame_start_c && !(final_slot_c && !LEFT_ALIGNED)) begin
                        err_nxt   = 1'b1;
                        restart_c = 1'b1;
                    end else begin
                        shreg_nxt = shift_c;
                        if (last_bit_c) begin
                            done_c  = 1'b1;
                            bit_nxt = '0;
                            if (final_slot_c) begin
                                slot_nxt  = '0;
                                state_nxt = frame_start_c ? ST_DELAY : ST_WAIT;
                            end else begin
                                slot_nxt = slot_cnt + CH_W'(1);
                            end
                        end else begin
                            bit_nxt = bit_cnt + CNT_W'(1);
                        end
                    end
                end
            endcase
        end

        // Frame (re)entry: left-aligned takes this bit as the slot-0 MSB.
        if (restart_c) begin
            slot_nxt = '0;
            if (LEFT_ALIGNED) begin
                shreg_nxt = shift_c;
                bit_nxt   = CNT_W'(1);
                state_nxt = ST_SHIFT;
            end else begin
                bit_nxt   = '0;
                state_nxt = ST_DELAY;
            end
        end

        // Single-entry output register; a blocked holder drops the new sample.
        if (done_c) begin
            if (i2s_tdm_dv && !i2s_tdm_dr) begin
                err_nxt = 1'b1;
            end else begin
                d_nxt  = shift_c;
                ch_nxt = slot_cnt;
                dv_nxt = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tdm_dec.sv
// Directed scoreboard bench for i2s_tdm_dec in TDM (4x24) and I2S (2x16) setups.
module tb_i2s_tdm_dec;
    import i2s_tdm_pkg::*;

    logic mclk = 1'b0;
    logic rst_n;
    always #5 mclk = ~mclk;

    logic        a_bclk, a_lrclk, a_sd, a_dr, a_dv, a_ferr;
    logic [23:0] a_d;
    logic [1:0]  a_ch;
    logic        b_bclk, b_lrclk, b_sd, b_dr, b_dv, b_ferr;
    logic [15:0] b_d;
    logic [0:0]  b_ch;

    i2s_tdm_dec #(
        .NR_CHANNELS(4), .OUTPUT_WIDTH(24), .LRCLK_POLARITY(LRCLK_POL_TDM),
        .LEFT_ALIGNED(ALIGN_LEFT), .MCLK_BCLK_RATIO(4)
    ) dut_tdm (
        .mclk(mclk), .rst_n(rst_n), .bclk(a_bclk), .lrclk(a_lrclk), .i2s_tdm(a_sd),
        .i2s_tdm_d(a_d), .i2s_tdm_ch(a_ch), .i2s_tdm_dv(a_dv), .i2s_tdm_dr(a_dr),
        .frame_err(a_ferr)
    );

    i2s_tdm_dec #(
        .NR_CHANNELS(2), .OUTPUT_WIDTH(16), .LRCLK_POLARITY(LRCLK_POL_I2S),
        .LEFT_ALIGNED(ALIGN_I2S), .MCLK_BCLK_RATIO(2)
    ) dut_i2s (
        .mclk(mclk), .rst_n(rst_n), .bclk(b_bclk), .lrclk(b_lrclk), .i2s_tdm(b_sd),
        .i2s_tdm_d(b_d), .i2s_tdm_ch(b_ch), .i2s_tdm_dv(b_dv), .i2s_tdm_dr(b_dr),
        .frame_err(b_ferr)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] a_q[$];
    logic [31:0] b_q[$];
    int a_xfers = 0, a_ferr_cnt = 0, b_xfers = 0, b_ferr_cnt = 0;
    logic        a_hold_v = 1'b0, b_hold_v = 1'b0;
    logic [31:0] a_hold, b_hold;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitors: pop the scoreboard on each transfer, check hold stability.
    always @(negedge mclk) begin
        if (!rst_n) begin
            a_hold_v = 1'b0;
        end else begin
            if (a_ferr) a_ferr_cnt++;
            if (a_dv && a_dr) begin
                a_xfers++;
                check("a_sample", {6'd0, a_ch, a_d}, (a_q.size() == 0) ? 32'hFFFF_FFFF : a_q.pop_front());
                a_hold_v = 1'b0;
            end else if (a_dv) begin
                if (a_hold_v) check("a_hold_stable", {6'd0, a_ch, a_d}, a_hold);
                a_hold   = {6'd0, a_ch, a_d};
                a_hold_v = 1'b1;
            end else begin
                a_hold_v = 1'b0;
            end
        end
    end

    always @(negedge mclk) begin
        if (!rst_n) begin
            b_hold_v = 1'b0;
        end else begin
            if (b_ferr) b_ferr_cnt++;
            if (b_dv && b_dr) begin
                b_xfers++;
                check("b_sample", {15'd0, b_ch, b_d}, (b_q.size() == 0) ? 32'hFFFF_FFFF : b_q.pop_front());
                b_hold_v = 1'b0;
            end else if (b_dv) begin
                if (b_hold_v) check("b_hold_stable", {15'd0, b_ch, b_d}, b_hold);
                b_hold   = {15'd0, b_ch, b_d};
                b_hold_v = 1'b1;
            end else begin
                b_hold_v = 1'b0;
            end
        end
    end

    // One TDM bit at ratio 4; called and returns at posedge+1.
    task automatic a_bit(input logic sd, input logic lr);
        a_bclk = 1'b0; a_sd = sd; a_lrclk = lr;
        repeat (2) @(posedge mclk);
        #1 a_bclk = 1'b1;
        repeat (2) @(posedge mclk);
        #1;
    endtask

    // One I2S bit at ratio 2.
    task automatic b_bit(input logic sd, input logic lr);
        b_bclk = 1'b0; b_sd = sd; b_lrclk = lr;
        @(posedge mclk);
        #1 b_bclk = 1'b1;
        @(posedge mclk);
        #1;
    endtask

    // TDM frame: 96 data bits then random padding up to nbits (or truncated),
    // optional ready-low window [dr_lo, dr_hi) and reset at bit rst_bit.
    task automatic a_frame(input logic [23:0] s0, input logic [23:0] s1, input logic [23:0] s2,
                           input logic [23:0] s3, input int nbits, input int dr_lo,
                           input int dr_hi, input int rst_bit);
        logic [23:0] smp [4];
        logic [23:0] cur;
        logic        sd;
        logic        held;
        int          slot, j;
        smp[0] = s0; smp[1] = s1; smp[2] = s2; smp[3] = s3;
        held = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            slot = i / 24;
            j    = i % 24;
            if (i == dr_lo) a_dr = 1'b0;
            if (i == dr_hi) begin a_dr = 1'b1; held = 1'b0; end
            if (i == rst_bit) begin
                a_bclk = 1'b0;
                rst_n  = 1'b0;
                #1;
                check("a_rst_dv", 32'(a_dv), 32'd0);
                check("a_rst_d", 32'(a_d), 32'd0);
                repeat (3) @(posedge mclk);
                #1 rst_n = 1'b1;
            end
            if (i < 96) begin
                cur = smp[slot[1:0]] << j;
                sd  = cur[23];
            end else begin
                sd = 1'($urandom_range(1, 0));
            end
            if (i < 96 && j == 23 && (rst_bit < 0 || rst_bit > i)) begin
                if (a_dr) begin
                    a_q.push_back({6'd0, slot[1:0], smp[slot[1:0]]});
                end else if (!held) begin
                    held = 1'b1;
                    a_q.push_back({6'd0, slot[1:0], smp[slot[1:0]]});
                end
            end
            a_bit(sd, i == 0);
        end
    endtask

    // I2S frame: lrclk falls one bit before the left MSB.
    task automatic b_frame(input logic [15:0] l, input logic [15:0] r);
        logic [15:0] cur;
        for (int k = 0; k < 32; k++) begin
            cur = ((k < 16) ? l : r) << (k % 16);
            if (k == 15) b_q.push_back({15'd0, 1'b0, l});
            if (k == 31) b_q.push_back({15'd0, 1'b1, r});
            b_bit(cur[15], (((k + 1) % 32) < 16) ? 1'b0 : 1'b1);
        end
    endtask

    task automatic drain();
        repeat (30) @(posedge mclk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int xb, eb;
        rst_n = 1'b0;
        a_bclk = 1'b0; a_lrclk = 1'b0; a_sd = 1'b0; a_dr = 1'b1;
        b_bclk = 1'b0; b_lrclk = 1'b1; b_sd = 1'b0; b_dr = 1'b1;
        repeat (3) @(posedge mclk);
        #1;
        check("a_rst_d0", 32'(a_d), 32'd0);
        check("a_rst_ch0", 32'(a_ch), 32'd0);
        check("a_rst_dv0", 32'(a_dv), 32'd0);
        check("a_rst_ferr0", 32'(a_ferr), 32'd0);
        check("b_rst_d0", 32'(b_d), 32'd0);
        check("b_rst_ch0", 32'(b_ch), 32'd0);
        check("b_rst_dv0", 32'(b_dv), 32'd0);
        check("b_rst_ferr0", 32'(b_ferr), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge mclk);
        #1;

        // I2S stereo at ratio 2
        for (int i = 0; i < 3; i++) b_bit(1'b0, 1'b1);
        b_bit(1'b0, 1'b0);
        b_frame(16'hA55A, 16'h5AA5);
        b_frame(16'hA55A, 16'h5AA5);
        drain();
        check("b_xfers", 32'(b_xfers), 32'd4);
        check("b_q_empty", 32'(b_q.size()), 32'd0);
        check("b_no_ferr", 32'(b_ferr_cnt), 32'd0);

        // TDM loopback, two back-to-back frames
        a_bit(1'b0, 1'b0);
        a_bit(1'b0, 1'b0);
        xb = a_xfers; eb = a_ferr_cnt;
        a_frame(24'h800001, 24'h7FFFFF, 24'h123456, 24'hABCDEF, 96, -1, -1, -1);
        a_frame(24'h800001, 24'h7FFFFF, 24'h123456, 24'hABCDEF, 96, -1, -1, -1);
        drain();
        check("a_tdm_xfers", 32'(a_xfers - xb), 32'd8);
        check("a_tdm_q_empty", 32'(a_q.size()), 32'd0);
        check("a_tdm_ferr", 32'(a_ferr_cnt - eb), 32'd0);

        // Padding bits after the four slots are ignored
        xb = a_xfers; eb = a_ferr_cnt;
        a_frame(24'h000001, 24'hFFFFFF, 24'h5A5A5A, 24'hC3C3C3, 128, -1, -1, -1);
        a_frame(24'h3C3C3C, 24'h000000, 24'h800000, 24'h7FFFFE, 128, -1, -1, -1);
        drain();
        check("a_pad_xfers", 32'(a_xfers - xb), 32'd8);
        check("a_pad_q_empty", 32'(a_q.size()), 32'd0);
        check("a_pad_ferr", 32'(a_ferr_cnt - eb), 32'd0);

        // Backpressure across slots 0 and 1: slot 1 dropped with one error pulse
        xb = a_xfers; eb = a_ferr_cnt;
        a_frame(24'h111111, 24'h222222, 24'h333333, 24'h444444, 96, 4, 60, -1);
        drain();
        check("a_bp_xfers", 32'(a_xfers - xb), 32'd3);
        check("a_bp_q_empty", 32'(a_q.size()), 32'd0);
        check("a_bp_ferr", 32'(a_ferr_cnt - eb), 32'd1);

        // Short frame: new frame start 10 bits into slot 2
        xb = a_xfers; eb = a_ferr_cnt;
        a_frame(24'hDEAD01, 24'hBEEF02, 24'hCAFE03, 24'hF00D04, 58, -1, -1, -1);
        a_frame(24'h0A0B0C, 24'h102030, 24'hFEDCBA, 24'h987654, 96, -1, -1, -1);
        drain();
        check("a_short_xfers", 32'(a_xfers - xb), 32'd6);
        check("a_short_q_empty", 32'(a_q.size()), 32'd0);
        check("a_short_ferr", 32'(a_ferr_cnt - eb), 32'd1);

        // Reset during slot 1; output resumes with ch0 of the next frame
        xb = a_xfers; eb = a_ferr_cnt;
        a_frame(24'h13579B, 24'h2468AC, 24'hECA864, 24'hB97531, 96, -1, -1, 30);
        a_frame(24'h55AA55, 24'hAA55AA, 24'h0F0F0F, 24'hF0F0F0, 96, -1, -1, -1);
        drain();
        check("a_rst_xfers", 32'(a_xfers - xb), 32'd5);
        check("a_rst_q_empty", 32'(a_q.size()), 32'd0);
        check("a_rst_ferr", 32'(a_ferr_cnt - eb), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
